// File: rtl/vram_arbiter.sv
// Arbitrates a single-port frame-buffer RAM between the 640x480 display scan, a buffered
// pixel writer and a full-screen clear. Define VRAM_ARB_BLANK_WR_EN to write only in blanking.
module vram_arbiter #(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       SHIFT     = 2,
   parameter int unsigned       ADDR_W    = 15,
   parameter logic [DATA_W-1:0] CLR_COLOR = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p_tick,
   input  logic              video_on,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              clr_req,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] rgb,
   output logic              rgb_on
);

   localparam int unsigned H_CELLS = 640 >> SHIFT;
   localparam int unsigned V_CELLS = 480 >> SHIFT;
   localparam int unsigned N_CELLS = H_CELLS * V_CELLS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_CELLS - 1);

   typedef enum logic {StIdle, StClear} state_e;

   state_e            state_q, state_d;
   logic              buf_full_q, buf_full_d;
   logic [ADDR_W-1:0] buf_addr_q;
   logic [DATA_W-1:0] buf_data_q;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              busy_q, wr_ready_q;
   logic              rd_q, rgb_on_q;
   logic [DATA_W-1:0] rgb_q;

   logic              disp_slot, wr_slot, drain, clr_wr, accept;
   logic [9:0]        x_cell, y_cell;
   logic [ADDR_W-1:0] y_ext, disp_addr;

   // Row base = y * (5 << (7-SHIFT)) built from two shifted copies of y.
   assign x_cell    = pixel_x >> SHIFT;
   assign y_cell    = pixel_y >> SHIFT;
   assign y_ext     = ADDR_W'(y_cell);
   assign disp_addr = (y_ext << (9 - SHIFT)) + (y_ext << (7 - SHIFT)) + ADDR_W'(x_cell);

   assign disp_slot = ~p_tick & video_on;
`ifdef VRAM_ARB_BLANK_WR_EN
   assign wr_slot = ~video_on;
`else
   assign wr_slot = ~disp_slot;
`endif

   // A buffered write always drains before the clear counter gets a slot.
   assign drain  = wr_slot & buf_full_q;
   assign clr_wr = wr_slot & ~buf_full_q & (state_q == StClear);
   assign accept = wr_valid & wr_ready_q;

   always_comb begin
      buf_full_d = buf_full_q;
      if (accept) begin
         buf_full_d = 1'b1;
      end else if (drain) begin
         buf_full_d = 1'b0;
      end

      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (clr_req) state_d = StClear;
         end
         StClear: begin
            if (clr_wr) begin
               if (clr_cnt_q == LAST_ADDR) begin
                  state_d   = StIdle;
                  clr_cnt_d = '0;
               end else begin
                  clr_cnt_d = clr_cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         buf_full_q <= 1'b0;
         buf_addr_q <= '0;
         buf_data_q <= '0;
         clr_cnt_q  <= '0;
         busy_q     <= 1'b0;
         wr_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         clr_cnt_q  <= clr_cnt_d;
         busy_q     <= (state_d == StClear);
         wr_ready_q <= ~buf_full_d & (state_d == StIdle);
         if (accept) begin
            buf_addr_q <= wr_addr;
            buf_data_q <= wr_data;
         end
      end
   end

   // Read data returns in the p_tick=1 cycle after the slot; rgb then holds for two clocks.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q     <= 1'b0;
         rgb_on_q <= 1'b0;
         rgb_q    <= '0;
      end else begin
         rd_q <= disp_slot;
         if (p_tick) begin
            rgb_on_q <= rd_q;
            rgb_q    <= rd_q ? mem_rdata : '0;
         end
      end
   end

   assign mem_we    = ~reset & (drain | clr_wr);
   assign mem_addr  = disp_slot ? disp_addr : (buf_full_q ? buf_addr_q : clr_cnt_q);
   assign mem_wdata = buf_full_q ? buf_data_q : CLR_COLOR;

   assign busy     = busy_q;
   assign wr_ready = wr_ready_q;
   assign rgb      = rgb_q;
   assign rgb_on   = rgb_on_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a write scoreboard checks every RAM write in order,
// and each scenario task checks handshakes, display fetch and clear sequencing inline.
`timescale 1ns/1ps
module tb_vram_arbiter;

   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned N_CELLS = 19200;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;

   logic              clk = 1'b0;
   logic              reset, p_tick, video_on, wr_valid, clr_req;
   logic [9:0]        pixel_x, pixel_y;
   logic [ADDR_W-1:0] wr_addr, mem_addr;
   logic [DATA_W-1:0] wr_data, mem_wdata, mem_rdata, rgb;
   logic              wr_ready, busy, mem_we, rgb_on;

   int  vectors = 0;
   int  miscompares = 0;
   int  tcnt = 0;
   bit  mon_en = 1'b0;
   wr_t exp_q[$];
   wr_t mon_e;
   logic [ADDR_W-1:0] mon_da;
   logic [DATA_W-1:0] ram [0:32767];

   vram_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .p_tick    (p_tick),
      .video_on  (video_on),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .clr_req   (clr_req),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .rgb       (rgb),
      .rgb_on    (rgb_on)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM model.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   // Write scoreboard and display-slot checker.
   always @(negedge clk) begin
      if (mon_en) begin
         if (mem_we) begin
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_write: got addr=%0d data=%0h, want no write", mem_addr,
                        mem_wdata);
            end else begin
               mon_e = exp_q.pop_front();
               if (mem_addr !== mon_e.a || mem_wdata !== mon_e.d) begin
                  miscompares++;
                  $display("FAIL write_order: got addr=%0d data=%0h, want addr=%0d data=%0h",
                           mem_addr, mem_wdata, mon_e.a, mon_e.d);
               end
            end
         end
         if (!p_tick && video_on && !reset) begin
            vectors++;
            mon_da = ADDR_W'((int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4);
            if (mem_we !== 1'b0 || mem_addr !== mon_da) begin
               miscompares++;
               $display("FAIL display_slot: got addr=%0d we=%b, want addr=%0d we=0", mem_addr,
                        mem_we, mon_da);
            end
         end
`ifdef VRAM_ARB_BLANK_WR_EN
         if (video_on && !reset) begin
            vectors++;
            if (mem_we !== 1'b0) begin
               miscompares++;
               $display("FAIL blank_only_write: got we=%b, want 0 in active video", mem_we);
            end
         end
`endif
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      p_tick = ~p_tick;
      tcnt++;
   endtask

   task automatic align_disp();
      cyc();
      if (p_tick) cyc();
   endtask

   task automatic rand_pix();
      pixel_x = 10'($urandom_range(0, 639));
      pixel_y = 10'($urandom_range(0, 479));
   endtask

   task automatic push_clear(input int n);
      wr_t t;
      for (int i = 0; i < n; i++) begin
         t.a = ADDR_W'(i);
         t.d = '0;
         exp_q.push_back(t);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) cyc();
      #3;
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_wr_ready: got %b want 1", wr_ready); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
      vectors++; if (rgb !== 8'h00) begin miscompares++; $display("FAIL rst_rgb: got %0h want 0", rgb); end
      vectors++; if (rgb_on !== 1'b0) begin miscompares++; $display("FAIL rst_rgb_on: got %b want 0", rgb_on); end
      vectors++; if (mem_we !== 1'b0) begin miscompares++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      cyc();
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (4) begin
         cyc();
         #3;
         vectors++; if (mem_we !== 1'b0 || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_rst_idle: got we=%b ready=%b want we=0 ready=1", mem_we, wr_ready);
         end
      end
   endtask

   task automatic test_display();
      ram[321] = 8'hA5;
      ram[0]   = 8'h3E;
      align_disp();
      video_on = 1'b1; pixel_x = 10'd4; pixel_y = 10'd8;
      #3;
      vectors++; if (mem_addr !== 15'd321 || mem_we !== 1'b0) begin
         miscompares++; $display("FAIL disp_addr: got addr=%0d we=%b want 321 we=0", mem_addr, mem_we);
      end
      cyc(); #3;
      vectors++; if (rgb_on !== 1'b0) begin miscompares++; $display("FAIL disp_early: got rgb_on=%b want 0", rgb_on); end
      cyc(); pixel_x = 10'd0; pixel_y = 10'd0; #3;
      vectors++; if (rgb !== 8'hA5 || rgb_on !== 1'b1) begin
         miscompares++; $display("FAIL disp_rgb: got %0h/%b want a5/1", rgb, rgb_on);
      end
      cyc(); video_on = 1'b0; #3;
      vectors++; if (rgb !== 8'hA5 || rgb_on !== 1'b1) begin
         miscompares++; $display("FAIL disp_hold: got %0h/%b want a5/1", rgb, rgb_on);
      end
      cyc(); #3;
      vectors++; if (rgb !== 8'h3E || rgb_on !== 1'b1) begin
         miscompares++; $display("FAIL disp_next: got %0h/%b want 3e/1", rgb, rgb_on);
      end
      cyc(); cyc(); #3;
      vectors++; if (rgb !== 8'h00 || rgb_on !== 1'b0) begin
         miscompares++; $display("FAIL disp_blank: got %0h/%b want 0/0", rgb, rgb_on);
      end
   endtask

   task automatic test_write();
      align_disp();
      video_on = 1'b1; rand_pix();
      wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 8'h3C;
      exp_q.push_back('{a: 15'd100, d: 8'h3C});
      #3;
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL wr_accept_ready: got %b want 1", wr_ready); end
      cyc(); wr_valid = 1'b0; rand_pix();
`ifdef VRAM_ARB_BLANK_WR_EN
      for (int i = 0; i < 6; i++) begin
         #3;
         vectors++; if (mem_we !== 1'b0 || wr_ready !== 1'b0) begin
            miscompares++; $display("FAIL wr_held_active: got we=%b ready=%b want 0/0", mem_we, wr_ready);
         end
         cyc(); rand_pix();
      end
      video_on = 1'b0;
`endif
      #3;
      vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL wr_busy_ready: got %b want 0", wr_ready); end
      vectors++; if (mem_we !== 1'b1 || mem_addr !== 15'd100 || mem_wdata !== 8'h3C) begin
         miscompares++;
         $display("FAIL wr_issue: got we=%b addr=%0d data=%0h want 1/100/3c", mem_we, mem_addr, mem_wdata);
      end
      cyc(); #3;
      vectors++; if (wr_ready !== 1'b1 || mem_we !== 1'b0) begin
         miscompares++; $display("FAIL wr_done: got ready=%b we=%b want 1/0", wr_ready, mem_we);
      end
      vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL wr_drained: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int tries;
      video_on = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wr_valid = 1'b1;
         wr_addr  = (k == 0) ? 15'd20000 : 15'(54 + k);
         wr_data  = 8'(8'h11 * (k + 1));
         #3;
         tries = 0;
         while (wr_ready !== 1'b1 && tries < 4) begin
            cyc(); #3; tries++;
         end
         vectors++; if (tries != 0) begin miscompares++; $display("FAIL b2b_ready_wait: got %0d waits want 0", tries); end
         exp_q.push_back('{a: wr_addr, d: wr_data});
         cyc(); wr_valid = 1'b0; #3;
         vectors++; if (wr_ready !== 1'b0 || mem_we !== 1'b1) begin
            miscompares++; $display("FAIL b2b_drain: got ready=%b we=%b want 0/1", wr_ready, mem_we);
         end
         cyc();
      end
      #3;
      vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL b2b_all_written: got %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_clear();
      int prev_size;
      bit done;
      cyc(); rand_pix(); video_on = (tcnt % 4) < 2;
      clr_req = 1'b1;
      push_clear(N_CELLS);
      #3;
      vectors++; if (busy !== 1'b0 || wr_ready !== 1'b1) begin
         miscompares++; $display("FAIL clr_req_cycle: got busy=%b ready=%b want 0/1", busy, wr_ready);
      end
      cyc(); clr_req = 1'b0; rand_pix(); video_on = (tcnt % 4) < 2; #3;
      vectors++; if (busy !== 1'b1 || wr_ready !== 1'b0) begin
         miscompares++; $display("FAIL clr_start: got busy=%b ready=%b want 1/0", busy, wr_ready);
      end
      prev_size = exp_q.size();
      done = 1'b0;
      for (int n = 0; n < 60000 && !done; n++) begin
         cyc(); rand_pix(); video_on = (tcnt % 4) < 2; #3;
         if (busy !== 1'b1) done = 1'b1;
         else prev_size = exp_q.size();
      end
      vectors++; if (!done) begin miscompares++; $display("FAIL clr_timeout: got busy=1 want busy=0 within budget"); end
      vectors++; if (prev_size !== 1 || exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL clr_end_timing: got %0d pending before, %0d after; want 1 and 0", prev_size, exp_q.size());
      end
      vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL clr_end_ready: got %b want 1", wr_ready); end
      exp_q.delete();
   endtask

   task automatic test_clr_with_buf();
      bit hit;
      align_disp();
      video_on = 1'b1; rand_pix();
      wr_valid = 1'b1; wr_addr = 15'd7; wr_data = 8'h77; clr_req = 1'b1;
      exp_q.push_back('{a: 15'd7, d: 8'h77});
      push_clear(N_CELLS);
      #3;
      vectors++; if (wr_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++; $display("FAIL cb_accept: got ready=%b busy=%b want 1/0", wr_ready, busy);
      end
      cyc(); wr_valid = 1'b0; clr_req = 1'b0; video_on = 1'b0; #3;
      vectors++; if (busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 15'd7) begin
         miscompares++;
         $display("FAIL cb_drain_first: got busy=%b we=%b addr=%0d want 1/1/7", busy, mem_we, mem_addr);
      end
      hit = 1'b0;
      for (int n = 0; n < 3000 && !hit; n++) begin
         cyc(); rand_pix(); video_on = (tcnt % 4) < 2; #3;
         if (exp_q.size() <= int'(N_CELLS) - 500) hit = 1'b1;
      end
      vectors++; if (!hit) begin miscompares++; $display("FAIL cb_progress: got %0d pending want <= 18700", exp_q.size()); end
      reset = 1'b1;
      #1;
      vectors++; if (busy !== 1'b0 || wr_ready !== 1'b1 || mem_we !== 1'b0 || rgb_on !== 1'b0) begin
         miscompares++;
         $display("FAIL cb_reset: got busy=%b ready=%b we=%b rgb_on=%b want 0/1/0/0", busy, wr_ready,
                  mem_we, rgb_on);
      end
      exp_q.delete();
      cyc(); cyc();
      reset = 1'b0;
      cyc(); clr_req = 1'b1; video_on = 1'b0;
      push_clear(4);
      cyc(); clr_req = 1'b0;
      hit = 1'b0;
      for (int n = 0; n < 20 && !hit; n++) begin
         #3;
         if (exp_q.size() == 0) hit = 1'b1;
         else cyc();
      end
      vectors++; if (!hit) begin miscompares++; $display("FAIL cb_restart: got %0d pending want 0", exp_q.size()); end
      reset = 1'b1;
      exp_q.delete();
      cyc(); cyc();
      reset = 1'b0;
      cyc(); cyc(); #3;
      vectors++; if (busy !== 1'b0 || mem_we !== 1'b0) begin
         miscompares++; $display("FAIL cb_final_idle: got busy=%b we=%b want 0/0", busy, mem_we);
      end
   endtask

   initial begin
      reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
      wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
      test_reset();
      test_display();
      test_write();
      test_back_to_back();
      test_clear();
      test_clr_with_buf();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port synchronous video RAM between the 640x480 display scan and a pixel writer (drawing logic or host).
- Sits between the VGA sync generator and the frame buffer. Consumes p_tick, video_on, pixel_x and pixel_y; produces the colour for the current pixel.
- Also runs a full-screen clear sequence on request.
- Frame buffer is a downscaled grid of (640>>SHIFT) x (480>>SHIFT) cells, addressed row-major.

Parameters:
- DATA_W, 8: colour word width.
- SHIFT, 2: pixel-to-cell downscale. Grid is H_CELLS = 640>>SHIFT, V_CELLS = 480>>SHIFT (160x120 by default).
- ADDR_W, 15: RAM address width; must satisfy 2^ADDR_W >= H_CELLS*V_CELLS.
- CLR_COLOR, 0: word written by the clear sequence.

Ports:
- clk  in  1  system clock (2x pixel rate)
- reset  in  1  asynchronous, active-high reset
- p_tick  in  1  pixel-rate enable from sync generator; alternates 0/1 every clk
- video_on  in  1  active display region
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- wr_valid  in  1  writer request
- wr_ready  out  1  one-entry write buffer empty; accept when wr_valid && wr_ready
- wr_addr  in  ADDR_W  cell address
- wr_data  in  DATA_W  cell colour
- clr_req  in  1  single-cycle clear request
- busy  out  1  clear sequence in progress
- mem_addr  out  ADDR_W  RAM address (combinational from slot)
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the address
- rgb  out  DATA_W  pixel colour, registered
- rgb_on  out  1  rgb corresponds to an active pixel

Behaviour:
- Reset values: wr_ready=1, busy=0, rgb=0, rgb_on=0, mem_we=0, write buffer empty, FSM=IDLE. mem_we is held 0 while reset is high.
- Display slot: cycle with p_tick=0 and video_on=1.
  - mem_addr = (pixel_y>>SHIFT)*H_CELLS + (pixel_x>>SHIFT), computed by shift-add with no multiplier; mem_we=0.
  - A 2-stage flag pipe marks the read. mem_rdata is captured into rgb at the end of the following cycle.
  - rgb and rgb_on update together two clk after the slot and hold for 2 clk.
  - When rgb_on=0, rgb=0.
- Writer slot: any cycle that is not a display slot. The display always wins its slot; the writer never blocks it.
- FSM states:
  - IDLE: if the buffer is full in a writer slot, drive mem_we=1 with mem_addr/mem_wdata from the buffer; the buffer empties and wr_ready=1 next cycle.
  - IDLE to CLEAR: on clr_req. clr_req while busy=1 is ignored.
  - CLEAR: busy=1, wr_ready=0. Each writer slot writes CLR_COLOR at clear counter clr_cnt, then clr_cnt+1.
  - CLEAR to IDLE: after writing address H_CELLS*V_CELLS-1, the next cycle returns to IDLE with busy=0. clr_cnt resets to 0.
- Buffer accept: on wr_valid && wr_ready, the buffer latches wr_addr/wr_data; wr_ready=0 next cycle. A write accepted in cycle N is written no earlier than cycle N+1.
- Simultaneous events:
  - clr_req with a full buffer: the buffered write drains in the first writer slot, then clearing starts. busy=1 from the cycle after clr_req.
  - clr_req and buffer accept in the same cycle: the accept happens and the write drains before clearing.
  - The buffered write is never lost.
- wr_addr >= H_CELLS*V_CELLS: write still issued (RAM decides); no error flag.
- Reset mid-clear: clear aborted, busy=0, buffer emptied, clr_cnt=0.
- Clear duration: 19200 writer slots for the default grid, with at least one writer slot per 2 clk.

Optional Feature:
- Macro: VRAM_ARB_BLANK_WR_EN.
- Defined: writer and clear slots are granted only when video_on=0, for tear-free updates. In the active region, cycles with p_tick=1 stay idle (mem_we=0).
- Undefined: behaviour as above, with writer slots interleaved during active video.

Test Plan:
- Reset then release: wr_ready=1, busy=0, rgb=0, rgb_on=0, mem_we=0 until the first writer-slot write.
- Display fetch at pixel_x=4, pixel_y=8, p_tick=0, video_on=1 -> mem_addr=2*160+1=321, mem_we=0. mem_rdata=8'hA5 next cycle -> rgb=8'hA5, rgb_on=1 two clk after the slot.
- wr_valid with addr=100, data=8'h3C during active video -> wr_ready=0 next cycle. Next p_tick=1 cycle: mem_we=1, mem_addr=100, mem_wdata=8'h3C. wr_ready=1 after.
- clr_req in IDLE -> busy=1; writes of 0 to addresses 0..19199 in order; busy=0 after the last; display reads unaffected throughout.
- clr_req with the buffer full (addr=7) -> addr 7 written first, then clear from 0. Reset asserted at clr_cnt=500 -> busy=0, clr_cnt=0.
- With VRAM_ARB_BLANK_WR_EN defined, wr_valid in the active region -> no mem_we until video_on=0, then a write on the first blanking cycle.
